imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart to the pipeline's instruction fetch: receives a byte stream over
//  a valid/ready link, packs little-endian 32-bit instructions and writes them into IMEM
//  through its write port. Holds the RISC-V core in reset (cpu_hold) until a complete,
//  checksum-verified program is in IMEM, then releases it to fetch from BASE_ADDR.
// PARAMETERS
//  PC_LENGTH    32   width of imem_addr, matches PC width
//  INST_LENGTH  32   instruction word width; fixed at 4 bytes
//  BASE_ADDR    0    byte address of first written word (word aligned)
//  MAX_WORDS    1024 largest legal word count N
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            begin (re)load; honoured only in IDLE, DONE, ERROR
//  rx_data      in   8            stream byte
//  rx_valid     in   1            rx_data valid
//  rx_ready     out  1            loader accepts byte; transfer = rx_valid & rx_ready
//  imem_we      out  1            one-cycle IMEM write strobe
//  imem_addr    out  PC_LENGTH    IMEM byte address
//  imem_wdata   out  INST_LENGTH  instruction word
//  cpu_hold     out  1            1 = keep core in reset
//  done         out  1            load finished, checksum OK
//  err          out  1            length or checksum error
//  words_loaded out  16           words written so far in current load
// BEHAVIOUR
//  Frame: LEN0, LEN1 (N = {LEN1,LEN0}), N*4 data bytes (LS byte first), CSUM byte.
//  CSUM must equal low 8 bits of the sum of LEN0, LEN1 and all data bytes.
//  States: IDLE -> LEN0 -> LEN1 -> DATA -> CSUM -> DONE | ERROR.
//   IDLE: rx_ready=0; start -> LEN0; clears counters, accumulator, done, err.
//   LEN0/LEN1/DATA/CSUM: rx_ready=1; state advances only on accepted byte.
//   LEN1 accept: N>MAX_WORDS -> ERROR; N==0 -> CSUM; else DATA.
//   DATA: byte counter 0..3; 4th byte completes word; after word N-1 -> CSUM.
//   CSUM accept: match -> DONE, mismatch -> ERROR.
//   DONE: cpu_hold=0, done=1, rx_ready=0. ERROR: cpu_hold=1, err=1, rx_ready=0.
//   start in DONE/ERROR -> LEN0 next cycle, cpu_hold=1, done/err/words_loaded cleared.
//   start in LEN0..CSUM ignored.
//  Write: cycle after 4th byte accepted, imem_we=1 for exactly 1 cycle with
//   imem_addr = BASE_ADDR + 4*k (k = word index, mod 2^PC_LENGTH), imem_wdata = packed
//   word; words_loaded increments in the same cycle. Bytes continue accepting meanwhile.
//  imem_addr/imem_wdata hold last written values when imem_we=0.
//  rx_valid gaps allowed anywhere; no timeout. rx_data ignored when transfer is 0.
//  Reset (any time, incl. mid-frame): state IDLE, cpu_hold=1, rx_ready=0, imem_we=0,
//   imem_addr=BASE_ADDR, imem_wdata=0, done=0, err=0, words_loaded=0; partial word dropped.
// TESTING
//  T1 start; bytes 02 00 93 00 50 00 13 81 10 00 89 -> we@0x0=0x00500093,
//     we@0x4=0x00108113, DONE, cpu_hold=0, done=1, words_loaded=2.
//  T2 same frame with CSUM 0x88 -> both words written, ERROR, err=1, cpu_hold stays 1.
//  T3 bytes 00 00 00 -> no imem_we, DONE; bytes 01 04 (N=1025) -> ERROR, no writes.
//  T4 T1 frame with rx_valid low 1-5 random cycles between bytes -> identical writes/result.
//  T5 rst after 6 data bytes -> IDLE, cpu_hold=1, one write only; start + T1 frame -> T1 result.
//  T6 after DONE, start + N=1 frame 01 00 13 00 00 00 14 -> we@0x0=0x00000013, DONE again.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian words from a valid/ready link into IMEM
// and keeps the core in reset until a length- and checksum-verified frame has been written.
module imem_loader #(
    parameter int unsigned          PC_LENGTH   = 32,
    parameter int unsigned          INST_LENGTH = 32,
    parameter logic [PC_LENGTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned          MAX_WORDS   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [PC_LENGTH-1:0]   imem_addr,
    output logic [INST_LENGTH-1:0] imem_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             len0_q, len0_d;
    logic [15:0]            len_q, len_d;
    logic [7:0]             sum_q, sum_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [INST_LENGTH-1:0] shift_q, shift_d;
    logic                   we_q, we_d;
    logic [PC_LENGTH-1:0]   addr_q, addr_d;
    logic [INST_LENGTH-1:0] wdata_q, wdata_d;
    logic [15:0]            words_q, words_d;

    logic        xfer;
    logic [15:0] n_rx;

    assign xfer = rx_valid & rx_ready;
    assign n_rx = {rx_data, len0_q};

    always_comb begin
        state_d    = state_q;
        len0_d     = len0_q;
        len_d      = len_q;
        sum_d      = sum_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLen0;
                    sum_d      = '0;
                    byte_cnt_d = '0;
                    words_d    = '0;
                    len_d      = '0;
                end
            end
            StLen0: begin
                if (xfer) begin
                    len0_d  = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = StLen1;
                end
            end
            StLen1: begin
                if (xfer) begin
                    len_d = n_rx;
                    sum_d = sum_q + rx_data;
                    if (32'(n_rx) > MAX_WORDS) begin
                        state_d = StError;
                    end else if (n_rx == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    sum_d      = sum_q + rx_data;
                    // Bytes shift in from the top so byte 0 ends up in the LS lane.
                    shift_d    = {rx_data, shift_q[INST_LENGTH-1:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = shift_d;
                        addr_d  = BASE_ADDR + (PC_LENGTH'(words_q) << 2);
                        words_d = words_q + 16'd1;
                        if (words_q == len_q - 16'd1) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    state_d = (rx_data == sum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len0_q     <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            len0_q     <= len0_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
        end
    end

    assign rx_ready     = (state_q == StLen0) || (state_q == StLen1) ||
                          (state_q == StData) || (state_q == StCsum);
    assign cpu_hold     = (state_q != StDone);
    assign done         = (state_q == StDone);
    assign err          = (state_q == StError);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

endmodule
